// File: rtl/mode_trap_ctrl.sv
// mode_trap_ctrl: privilege mode register (M/U) plus a prioritised interrupt
// and exception trap requester. Raw interrupt lines are synchronised, edge
// sources are latched, the eligible source with the highest priority wins, and
// one registered trap request with a stable cause and handler address is held
// towards WB until it is acknowledged.
//
// state  | meaning
// IDLE   | no trap outstanding; exceptions or the gated interrupt winner load a request
// REQ    | trap_req held with frozen cause/pc; only an exception may replace an interrupt
module mode_trap_ctrl #(
    parameter int          NUM_SRC   = 16,
    parameter int          PRIO_W    = 3,
    parameter logic [31:0] EDGE_MASK = 32'h0,
    parameter int          HAS_U     = 1,
    parameter int          PC_SZ     = 32,
    parameter int          RSZ       = 32
) (
    input  logic                      clk_in,
    input  logic                      reset_n_in,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [NUM_SRC-1:0]        src_clr,
    input  logic                      mstatus_mie,
    input  logic [1:0]                mstatus_mpp,
    input  logic                      mret,
    input  logic                      exception_flag,
    input  logic [RSZ-1:0]            exc_cause,
    input  logic [RSZ-1:0]            mtvec,
    output logic                      trap_req,
    input  logic                      trap_ack,
    output logic                      trap_is_irq,
    output logic [RSZ-1:0]            trap_cause,
    output logic [PC_SZ-1:0]          trap_pc,
    output logic [NUM_SRC-1:0]        pending,
    output logic [1:0]                mode,
    output logic [1:0]                nxt_mode
);

    localparam int                 IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [NUM_SRC-1:0] EDGE  = EDGE_MASK[NUM_SRC-1:0];

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_sync1, r_sync2, r_sync_d, r_edge_pend;
    logic               r_req, r_is_irq;
    logic [RSZ-1:0]     r_cause;
    logic [PC_SZ-1:0]   r_pc;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_mode;

    logic [NUM_SRC-1:0] w_rise, w_ack_clr, w_pending;
    logic               w_win_vld, w_irq_on;
    logic [IDX_W-1:0]   w_win_idx;
    logic [PRIO_W-1:0]  w_win_prio;
    logic [PC_SZ-1:0]   w_base, w_irq_pc;
    logic [RSZ-1:0]     w_irq_cause;
    logic [1:0]         w_nxt_mode;

    // Two-flop synchroniser per line plus a delay stage for rising-edge detection
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync1  <= src_irq;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Edge detect and the clear raised by acknowledging the granted edge source
    always_comb begin
        w_rise    = r_sync2 & ~r_sync_d & EDGE;
        w_ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_clr[i] = (r_state == ST_REQ) && trap_ack && r_is_irq && (r_idx == IDX_W'(i));
        end
    end

    // Latched edge pending bits; a new edge wins over a clear in the same cycle
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_edge_pend <= '0;
        end else begin
            r_edge_pend <= ((r_edge_pend & ~(src_clr | w_ack_clr)) | w_rise) & EDGE;
        end
    end

    // Arbitration: highest priority among eligible sources, ties to the lowest index
    always_comb begin
        w_pending  = (r_sync2 & ~EDGE) | r_edge_pend;
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_pending[i] && src_en[i] && (src_prio[i*PRIO_W +: PRIO_W] != '0) &&
                (!w_win_vld || (src_prio[i*PRIO_W +: PRIO_W] > w_win_prio))) begin
                w_win_vld  = 1'b1;
                w_win_idx  = IDX_W'(i);
                w_win_prio = src_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    // Global gate, interrupt cause and handler address (vectored mode offsets by 4*index)
    always_comb begin
        w_irq_on    = (r_mode != 2'b11) || mstatus_mie;
        w_base      = {mtvec[PC_SZ-1:2], 2'b00};
        w_irq_pc    = (mtvec[1:0] == 2'b01) ? (w_base + (PC_SZ'(w_win_idx) << 2)) : w_base;
        w_irq_cause = RSZ'(w_win_idx) | {1'b1, {(RSZ-1){1'b0}}};
    end

    // Trap request FSM with registered request, type, cause and handler address
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state  <= ST_IDLE;
            r_req    <= 1'b0;
            r_is_irq <= 1'b0;
            r_cause  <= '0;
            r_pc     <= '0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (exception_flag) begin
                        r_state  <= ST_REQ;
                        r_req    <= 1'b1;
                        r_is_irq <= 1'b0;
                        r_cause  <= exc_cause;
                        r_pc     <= w_base;
                    end else if (w_win_vld && w_irq_on) begin
                        r_state  <= ST_REQ;
                        r_req    <= 1'b1;
                        r_is_irq <= 1'b1;
                        r_cause  <= w_irq_cause;
                        r_pc     <= w_irq_pc;
                        r_idx    <= w_win_idx;
                    end
                end
                ST_REQ: begin
                    if (trap_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end else if (exception_flag && r_is_irq) begin
                        // the pipeline cannot take the interrupt past a faulting instruction
                        r_is_irq <= 1'b0;
                        r_cause  <= exc_cause;
                        r_pc     <= w_base;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Next mode: trap entry wins over mret; without U mode the hart stays in M
    always_comb begin
        w_nxt_mode = r_mode;
        if (HAS_U == 0) begin
            w_nxt_mode = 2'b11;
        end else if (trap_ack) begin
            w_nxt_mode = 2'b11;
        end else if (mret) begin
            w_nxt_mode = (mstatus_mpp == 2'b11) ? 2'b11 : 2'b00;
        end
    end

    // Privilege mode register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_mode <= 2'b11;
        end else begin
            r_mode <= w_nxt_mode;
        end
    end

    assign trap_req    = r_req;
    assign trap_is_irq = r_is_irq;
    assign trap_cause  = r_cause;
    assign trap_pc     = r_pc;
    assign pending     = w_pending;
    assign mode        = r_mode;
    assign nxt_mode    = w_nxt_mode;

endmodule

// File: tb/tb_mode_trap_ctrl.sv
// Bench for mode_trap_ctrl: table of arbitration vectors plus hand-written
// sequences for timing, edge latching, exception replacement and mode changes.
// Every trap presented to WB is checked against a queue of expected traps.
module tb_mode_trap_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [15:0] src_irq, src_en, src_clr;
    logic [47:0] src_prio;
    logic        mstatus_mie;
    logic [1:0]  mstatus_mpp;
    logic        mret, exception_flag, trap_ack;
    logic [31:0] exc_cause, mtvec;
    logic        trap_req, trap_is_irq;
    logic [31:0] trap_cause, trap_pc;
    logic [15:0] pending;
    logic [1:0]  mode, nxt_mode;

    mode_trap_ctrl #(
        .NUM_SRC(16), .PRIO_W(3), .EDGE_MASK(32'h0000_0800),
        .HAS_U(1), .PC_SZ(32), .RSZ(32)
    ) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .src_irq(src_irq), .src_en(src_en), .src_prio(src_prio), .src_clr(src_clr),
        .mstatus_mie(mstatus_mie), .mstatus_mpp(mstatus_mpp), .mret(mret),
        .exception_flag(exception_flag), .exc_cause(exc_cause), .mtvec(mtvec),
        .trap_req(trap_req), .trap_ack(trap_ack), .trap_is_irq(trap_is_irq),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .pending(pending),
        .mode(mode), .nxt_mode(nxt_mode)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          is_irq;
        logic [31:0] cause;
        logic [31:0] pc;
    } sb_t;

    typedef struct {
        logic [15:0] irq;
        logic [15:0] en;
        logic [47:0] prio;
        logic        mie;
        logic [31:0] tvec;
        bit          exp_req;
        int          exp_idx;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[9];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit          p_req = 1'b0;
    bit          p_irq = 1'b0;
    logic [31:0] p_cause = '0;

    function automatic logic [47:0] pv(int idx, int val);
        logic [47:0] v;
        v = '0;
        v[idx*3 +: 3] = 3'(val);
        return v;
    endfunction

    function automatic logic [31:0] model_pc(logic [31:0] tv, bit irq, int idx);
        logic [31:0] base;
        base = {tv[31:2], 2'b00};
        if (irq && tv[1:0] == 2'b01) return base + 32'(idx * 4);
        return base;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic push_irq(int idx);
        sb_t e;
        e.is_irq = 1'b1;
        e.cause  = 32'h8000_0000 | 32'(idx);
        e.pc     = model_pc(mtvec, 1'b1, idx);
        sb_q.push_back(e);
    endtask

    task automatic push_exc(logic [31:0] cause);
        sb_t e;
        e.is_irq = 1'b0;
        e.cause  = cause;
        e.pc     = model_pc(mtvec, 1'b0, 0);
        sb_q.push_back(e);
    endtask

    task automatic wait_req(string name);
        int c;
        c = 0;
        while (trap_req !== 1'b1 && c < 20) begin
            tick(1);
            c++;
        end
        check(name, 32'(trap_req), 32'd1);
    endtask

    task automatic do_ack();
        trap_ack = 1'b1;
        tick(1);
        trap_ack = 1'b0;
    endtask

    // Scoreboard monitor: each new or replaced trap request pops one expectation
    initial begin
        sb_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (trap_req === 1'b1 && (!p_req || trap_is_irq !== p_irq || trap_cause !== p_cause)) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_trap: got cause %h want no trap", trap_cause);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_is_irq", 32'(trap_is_irq), 32'(e.is_irq));
                    check("sb_cause", trap_cause, e.cause);
                    check("sb_pc", trap_pc, e.pc);
                end
            end
            p_req   = trap_req;
            p_irq   = trap_is_irq;
            p_cause = trap_cause;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h0080, 16'hFFFF, pv(7,2),                    1'b1, 32'h1001, 1'b1, 7};
        tbl[1] = '{16'h0208, 16'hFFFF, pv(3,5) | pv(9,5),          1'b1, 32'h1001, 1'b1, 3};
        tbl[2] = '{16'h0024, 16'hFFFF, pv(2,1) | pv(5,6),          1'b1, 32'h1001, 1'b1, 5};
        tbl[3] = '{16'h0010, 16'hFFEF, pv(4,3),                    1'b1, 32'h1001, 1'b0, 0};
        tbl[4] = '{16'h0040, 16'hFFFF, pv(1,3),                    1'b1, 32'h1001, 1'b0, 0};
        tbl[5] = '{16'h0002, 16'hFFFF, pv(1,3),                    1'b0, 32'h1001, 1'b0, 0};
        tbl[6] = '{16'h8001, 16'hFFFF, pv(0,7) | pv(15,7),         1'b1, 32'h1001, 1'b1, 0};
        tbl[7] = '{16'h7000, 16'hDFFF, pv(12,4) | pv(13,7) | pv(14,7), 1'b1, 32'h1001, 1'b1, 14};
        tbl[8] = '{16'h0102, 16'hFFFF, pv(1,1) | pv(8,2),          1'b1, 32'h2000, 1'b1, 8};

        reset_n_in = 1'b0;
        src_irq = '0; src_en = '0; src_clr = '0; src_prio = '0;
        mstatus_mie = 1'b0; mstatus_mpp = 2'b00; mret = 1'b0;
        exception_flag = 1'b0; exc_cause = '0; mtvec = '0; trap_ack = 1'b0;
        tick(3);
        reset_n_in = 1'b1;

        // reset state held with all inputs idle
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("rst_mode", 32'(mode), 32'd3);
            check("rst_req", 32'(trap_req), 32'd0);
            check("rst_pending", 32'(pending), 32'd0);
        end

        // level source 7: pending at cycle 2, trap_req at cycle 3, vectored pc
        mtvec = 32'h0000_1001; mstatus_mie = 1'b1; src_en = '1; src_prio = pv(7,2);
        push_irq(7);
        src_irq = 16'h0080;
        tick(1);
        check("lvl_pend_c1", 32'(pending[7]), 32'd0);
        tick(1);
        check("lvl_pend_c2", 32'(pending[7]), 32'd1);
        check("lvl_req_c2", 32'(trap_req), 32'd0);
        tick(1);
        check("lvl_req_c3", 32'(trap_req), 32'd1);
        check("lvl_cause", trap_cause, 32'h8000_0007);
        check("lvl_pc", trap_pc, 32'h0000_101C);
        src_irq = '0;
        tick(3);
        do_ack();
        check("lvl_ack_req", 32'(trap_req), 32'd0);
        check("lvl_ack_mode", 32'(mode), 32'd3);
        tick(3);

        // arbitration table
        for (int k = 0; k < 9; k++) begin
            src_en = tbl[k].en; src_prio = tbl[k].prio;
            mstatus_mie = tbl[k].mie; mtvec = tbl[k].tvec;
            if (tbl[k].exp_req) push_irq(tbl[k].exp_idx);
            src_irq = tbl[k].irq;
            tick(4);
            check($sformatf("tbl%0d_req", k), 32'(trap_req), 32'(tbl[k].exp_req));
            src_irq = '0;
            tick(3);
            if (trap_req) do_ack();
            tick(3);
        end

        // equal priorities 3 and 9, back-to-back re-request, then the loser
        mtvec = 32'h0000_1001; mstatus_mie = 1'b1; src_en = '1; src_prio = pv(3,5) | pv(9,5);
        push_irq(3);
        src_irq = 16'h0208;
        wait_req("tie_first_req");
        check("tie_first_cause", trap_cause, 32'h8000_0003);
        push_irq(3);
        do_ack();
        check("tie_gap", 32'(trap_req), 32'd0);
        tick(1);
        check("tie_rereq", 32'(trap_req), 32'd1);
        check("tie_rereq_cause", trap_cause, 32'h8000_0003);
        src_irq = 16'h0200;
        tick(3);
        check("tie_held", trap_cause, 32'h8000_0003);
        push_irq(9);
        do_ack();
        wait_req("tie_second_req");
        check("tie_second_cause", trap_cause, 32'h8000_0009);
        src_irq = '0;
        tick(3);
        do_ack();
        tick(4);
        check("tie_idle", 32'(trap_req), 32'd0);

        // edge source 11: latch, clear before request, then pulse, trap and ack-clear
        src_en = 16'hF7FF; src_prio = pv(11,4);
        src_irq = 16'h0800;
        tick(1);
        src_irq = '0;
        tick(1);
        check("edge_pend_c2", 32'(pending[11]), 32'd0);
        tick(1);
        check("edge_pend_c3", 32'(pending[11]), 32'd1);
        tick(3);
        check("edge_latched", 32'(pending[11]), 32'd1);
        src_clr = 16'h0800;
        tick(1);
        src_clr = '0;
        check("edge_clr", 32'(pending[11]), 32'd0);
        src_en = '1;
        tick(5);
        check("edge_no_trap", 32'(trap_req), 32'd0);
        push_irq(11);
        src_irq = 16'h0800;
        tick(1);
        src_irq = '0;
        wait_req("edge_req");
        check("edge_req_pend", 32'(pending[11]), 32'd1);
        check("edge_pc", trap_pc, 32'h0000_102C);
        do_ack();
        check("edge_ack_clr", 32'(pending[11]), 32'd0);
        tick(4);
        check("edge_idle", 32'(trap_req), 32'd0);

        // exception replaces a held interrupt without dropping trap_req
        src_prio = pv(5,3);
        push_irq(5);
        src_irq = 16'h0020;
        wait_req("exc_irq_req");
        tick(2);
        check("exc_irq_held", 32'(trap_is_irq), 32'd1);
        push_exc(32'd2);
        exception_flag = 1'b1; exc_cause = 32'd2;
        tick(1);
        exception_flag = 1'b0;
        check("exc_req", 32'(trap_req), 32'd1);
        check("exc_is_irq", 32'(trap_is_irq), 32'd0);
        check("exc_cause", trap_cause, 32'd2);
        check("exc_pc", trap_pc, 32'h0000_1000);
        src_irq = '0;
        tick(3);
        check("exc_still_req", 32'(trap_req), 32'd1);
        do_ack();
        check("exc_ack", 32'(trap_req), 32'd0);
        tick(3);

        // mode: mret to U, trap taken in U with mie=0, trap beats simultaneous mret
        mstatus_mpp = 2'b00; mret = 1'b1;
        #1;
        check("mret_nxt", 32'(nxt_mode), 32'd0);
        tick(1);
        mret = 1'b0;
        check("mret_mode_u", 32'(mode), 32'd0);
        mstatus_mie = 1'b0; src_prio = pv(7,2);
        push_irq(7);
        src_irq = 16'h0080;
        wait_req("u_trap_req");
        check("u_mode_held", 32'(mode), 32'd0);
        src_irq = '0;
        tick(3);
        mret = 1'b1; trap_ack = 1'b1;
        #1;
        check("ack_mret_nxt", 32'(nxt_mode), 32'd3);
        tick(1);
        mret = 1'b0; trap_ack = 1'b0;
        check("ack_mret_mode", 32'(mode), 32'd3);
        check("ack_mret_req", 32'(trap_req), 32'd0);
        mstatus_mpp = 2'b11; mret = 1'b1;
        tick(1);
        mret = 1'b0;
        check("mret_mpp3", 32'(mode), 32'd3);
        mstatus_mpp = 2'b01; mret = 1'b1;
        tick(1);
        mret = 1'b0;
        check("mret_mpp1", 32'(mode), 32'd0);
        mstatus_mpp = 2'b11; mret = 1'b1;
        tick(1);
        mret = 1'b0;
        check("mret_back_m", 32'(mode), 32'd3);

        // reset while a request is outstanding drops it at once
        mstatus_mie = 1'b1;
        push_irq(7);
        src_irq = 16'h0080;
        wait_req("rst_mid_req");
        reset_n_in = 1'b0;
        #1;
        check("rst_mid_drop", 32'(trap_req), 32'd0);
        check("rst_mid_cause", trap_cause, 32'd0);
        check("rst_mid_pc", trap_pc, 32'd0);
        src_irq = '0;
        tick(2);
        reset_n_in = 1'b1;
        tick(5);
        check("rst_mid_idle", 32'(trap_req), 32'd0);
        check("rst_mid_pend", 32'(pending), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
